button_cmd_scheduler: RTL and testbench

- Sits between the per-button debouncers and the battleship game FSM.
- Takes five debounced button levels (up, down, left, right, fire) and turns rising edges into one-at-a-time commands on a valid/ready interface.
- Arbitrates simultaneous presses with fixed priority.
- Generates auto-repeat commands for a held direction button, paced by the refresh tick.

---
 rtl/button_cmd_scheduler_if.sv | 12 +
 rtl/button_cmd_scheduler.sv | 128 ++++++++++++
 tb/tb_button_cmd_scheduler.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_cmd_scheduler_if.sv
// Command handshake between the button scheduler and the game FSM.
// Ports: cmd_valid/cmd_code/cmd_repeat from producer, cmd_ready from consumer.
// master = scheduler side, slave = game FSM side.
interface button_cmd_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;
  logic       cmd_repeat;

  modport master (output cmd_valid, output cmd_code, output cmd_repeat, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, input cmd_repeat, output cmd_ready);
endinterface

// File: rtl/button_cmd_scheduler.sv
// Turns debounced button rising edges into one-at-a-time commands, fixed priority
// up > down > left > right > fire, with tick-paced auto-repeat of a lone held direction.
// Ports: clk, reset (async, active-high), tick (refresh enable), btn_level[4:0],
// cmd (valid/ready command bus, master side).
// Latency: rise seen at edge k, command valid after edge k+1; output holds under backpressure.
module button_cmd_scheduler #(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int CNT_W        = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [4:0]                    btn_level,
  button_cmd_scheduler_if.master        cmd
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t           state;
  logic [4:0]       prev_level;
  logic [4:0]       pending;
  logic             repeat_req;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       held_idx;

  logic [4:0] rise;
  logic       load;
  logic       pend_any;
  logic [2:0] pend_idx;
  logic [4:0] grant_vec;
  logic       fresh_dir;
  logic       rep_take;
  logic       abort;

  always_comb begin
    rise     = btn_level & ~prev_level;
    load     = !cmd.cmd_valid || cmd.cmd_ready;
    pend_any = |pending;
    // Scan from the top so the lowest set index is the one left standing.
    pend_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) pend_idx = 3'(i);
    end
    grant_vec = '0;
    if (load && pend_any) grant_vec[pend_idx] = 1'b1;
    rep_take  = load && !pend_any && repeat_req;
    // A direction grant arms auto-repeat only if that button is the only one down;
    // grant_vec is one-hot, so equality checks both conditions at once.
    fresh_dir = load && pend_any && !pend_idx[2] && (btn_level == grant_vec);
    // Held button released, or anything else pressed alongside it.
    abort     = (state != IDLE) && (btn_level != (5'b00001 << held_idx));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_level     <= '0;
      pending        <= '0;
      repeat_req     <= 1'b0;
      state          <= IDLE;
      cnt            <= '0;
      held_idx       <= 2'd0;
      cmd.cmd_valid  <= 1'b0;
      cmd.cmd_code   <= 3'd0;
      cmd.cmd_repeat <= 1'b0;
    end else begin
      prev_level <= btn_level;
      // A new rise on a bit being granted this cycle keeps it pending.
      pending    <= (pending & ~grant_vec) | rise;

      if (load) begin
        if (pend_any) begin
          cmd.cmd_valid  <= 1'b1;
          cmd.cmd_code   <= pend_idx;
          cmd.cmd_repeat <= 1'b0;
        end else if (repeat_req) begin
          cmd.cmd_valid  <= 1'b1;
          cmd.cmd_code   <= {1'b0, held_idx};
          cmd.cmd_repeat <= 1'b1;
        end else begin
          cmd.cmd_valid  <= 1'b0;
        end
      end

      // Consumption first; a same-cycle repeat set below overrides it (coalescing).
      if (rep_take) repeat_req <= 1'b0;

      if (abort) begin
        state      <= IDLE;
        cnt        <= '0;
        repeat_req <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fresh_dir) begin
              state    <= HOLD;
              held_idx <= pend_idx[1:0];
              cnt      <= '0;
            end
          end
          HOLD: begin
            if (tick) begin
              if (cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                repeat_req <= 1'b1;
                cnt        <= '0;
                state      <= REPEAT;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (tick) begin
              if (cnt == CNT_W'(REPEAT_RATE - 1)) begin
                repeat_req <= 1'b1;
                cnt        <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_cmd_scheduler.sv
module tb_button_cmd_scheduler;
  localparam int D = 3;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [4:0] btn_level = '0;

  button_cmd_scheduler_if bus();

  button_cmd_scheduler #(.REPEAT_DELAY(D), .REPEAT_RATE(R), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_level(btn_level), .cmd(bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: press events, a pending set, and a "ticks held since grant"
  // count from which repeat instants follow as D, D+R, D+2R, ...
  logic [4:0] m_prev, m_pend;
  int         m_held, m_ticks;
  bit         m_req, m_valid, m_rep;
  int         m_code;

  int log_code[$];
  int log_rep[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    logic [4:0] rise;
    bit load, took;
    int g;
    if (reset) begin
      m_prev = '0; m_pend = '0; m_held = -1; m_ticks = 0; m_req = 0;
      m_valid = 0; m_code = 0; m_rep = 0;
      return;
    end
    rise = btn_level & ~m_prev;
    load = !m_valid || bus.cmd_ready;
    g = -1;
    took = 0;
    if (load) begin
      for (int i = 4; i >= 0; i--) if (m_pend[i]) g = i;
      if (g >= 0) begin
        m_valid = 1; m_code = g; m_rep = 0;
      end else if (m_req) begin
        m_valid = 1; m_code = m_held; m_rep = 1; took = 1;
      end else begin
        m_valid = 0;
      end
    end
    if (took) m_req = 0;
    if (m_held >= 0) begin
      if (!btn_level[m_held] || ((btn_level & ~(5'b00001 << m_held)) != 5'd0)) begin
        m_held = -1; m_ticks = 0; m_req = 0;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks >= D && ((m_ticks - D) % R) == 0) m_req = 1;
      end
    end else if (g >= 0 && g < 4 && btn_level == (5'b00001 << g)) begin
      m_held = g; m_ticks = 0;
    end
    if (g >= 0) m_pend[g] = 1'b0;
    m_pend = m_pend | rise;
    m_prev = btn_level;
  endfunction

  // Monitor, model update and per-cycle comparison.
  always @(posedge clk) begin
    if (!reset && bus.cmd_valid && bus.cmd_ready) begin
      log_code.push_back(int'(bus.cmd_code));
      log_rep.push_back(int'(bus.cmd_repeat));
    end
    model_step();
    #1;
    check("cycle valid", int'(bus.cmd_valid), int'(m_valid));
    if (m_valid) begin
      check("cycle code", int'(bus.cmd_code), m_code);
      check("cycle repeat", int'(bus.cmd_repeat), int'(m_rep));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      cyc(gap);
    end
  endtask

  // w packs entry i as {repeat, code[2:0]} in nibble i.
  task automatic expect_log(input string name, input int n, input logic [31:0] w);
    check({name, " count"}, log_code.size(), n);
    for (int i = 0; i < n && i < log_code.size(); i++) begin
      check({name, " code"}, log_code[i], int'(w[4*i +: 3]));
      check({name, " repeat"}, log_rep[i], int'(w[4*i + 3]));
    end
    log_code.delete();
    log_rep.delete();
  endtask

  initial begin
    bus.cmd_ready = 1'b1;
    btn_level = 5'b11111;
    #1 reset = 1'b1;

    // Reset with all buttons down: outputs cleared.
    cyc(3);
    check("reset valid", int'(bus.cmd_valid), 0);
    check("reset code", int'(bus.cmd_code), 0);
    check("reset repeat", int'(bus.cmd_repeat), 0);
    reset = 1'b0;
    cyc(12);
    expect_log("reset order", 5, 32'h0004_3210);

    // Single fire press: one command two edges later, no repeats while held.
    btn_level = '0;
    cyc(5);
    log_code.delete(); log_rep.delete();
    btn_level = 5'b10000;
    @(posedge clk); #2;
    check("fire edge k", int'(bus.cmd_valid), 0);
    @(posedge clk); #2;
    check("fire edge k+1 valid", int'(bus.cmd_valid), 1);
    check("fire edge k+1 code", int'(bus.cmd_code), 4);
    pulse_ticks(200, 0);
    expect_log("fire once", 1, 32'h4);
    btn_level = '0;
    cyc(4);

    // Simultaneous right + up under backpressure.
    bus.cmd_ready = 1'b0;
    btn_level = 5'b01001;
    cyc(10);
    check("simul held valid", int'(bus.cmd_valid), 1);
    check("simul held code", int'(bus.cmd_code), 0);
    bus.cmd_ready = 1'b1;
    @(posedge clk); #2;
    check("simul second code", int'(bus.cmd_code), 3);
    @(posedge clk); #2;
    check("simul drained", int'(bus.cmd_valid), 0);
    @(negedge clk);
    expect_log("simul", 2, 32'h30);
    btn_level = '0;
    cyc(4);

    // Auto-repeat of left: repeats after ticks 3, 5, 7; release before tick 9.
    btn_level = 5'b00100;
    cyc(4);
    pulse_ticks(8, 3);
    btn_level = '0;
    cyc(10);
    expect_log("repeat", 4, 32'hAAA2);

    // Down into repeat, then fire joins: abort, fire issued, no more repeats.
    btn_level = 5'b00010;
    cyc(4);
    pulse_ticks(3, 3);
    cyc(4);
    btn_level = 5'b10010;
    cyc(4);
    pulse_ticks(6, 3);
    expect_log("abort", 3, 32'h491);
    btn_level = '0;
    cyc(4);

    // Coalescing: first repeat under backpressure sits in the output register,
    // the next two merge into one request; two repeats drain once ready returns.
    btn_level = 5'b00001;
    cyc(4);
    pulse_ticks(3, 3);
    cyc(4);
    expect_log("coal pre", 2, 32'h80);
    bus.cmd_ready = 1'b0;
    pulse_ticks(6, 3);
    cyc(3);
    bus.cmd_ready = 1'b1;
    cyc(6);
    expect_log("coal post", 2, 32'h88);
    btn_level = '0;
    cyc(4);

    // Random traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 1999) == 0) reset = 1'b1;
      if ($urandom_range(0, 23) == 0) begin
        case ($urandom_range(0, 3))
          0: btn_level = '0;
          1: btn_level = 5'b00001 << $urandom_range(0, 4);
          2: btn_level = 5'($urandom);
          default: begin
            int k;
            k = int'($urandom_range(0, 4));
            btn_level[k] = ~btn_level[k];
          end
        endcase
      end
      tick = ($urandom_range(0, 3) == 0);
      bus.cmd_ready = ($urandom_range(0, 3) != 0);
    end
    reset = 1'b0;
    tick = 1'b0;
    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
